// File: rtl/systolic_feeder_pkg.sv
// Shared state encoding, default geometry and small helpers for the systolic array input feeder.
package systolic_feeder_pkg;

   localparam int DEF_DIM        = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_MAX_K      = 255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } feed_state_t;

   // Last drain count: the corner PE needs 2*DIM-1 edges after the final beat.
   function automatic int drain_last(input int dim);
      return 2 * dim - 2;
   endfunction

   function automatic int clamp_k(input int k, input int max_k);
      return (k > max_k) ? max_k : k;
   endfunction

endpackage

// File: rtl/systolic_feeder_skew.sv
// Zero-resettable shift line used to skew one lane of the array edge; shifts every cycle.
module skew_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [DEPTH-1:0][WIDTH-1:0] stage;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stage <= '0;
      end else begin
         stage[0] <= d;
         for (int k = 1; k < DEPTH; k++) begin
            stage[k] <= stage[k-1];
         end
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Input-side feeder for the DIM x DIM MAC array: skews A/B lanes and sequences start_operation.
// Optional feed-stall counter enabled with `define FEEDER_STALL_CNT_EN.
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int DIM        = DEF_DIM,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_K      = DEF_MAX_K
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          start_i,
   input  logic [$clog2(MAX_K+1)-1:0]    k_len_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [DIM*DATA_WIDTH-1:0]     a_vec_i,
   input  logic [DIM*DATA_WIDTH-1:0]     b_vec_i,
   output logic [DIM*DATA_WIDTH-1:0]     a_edge_o,
   output logic [DIM*DATA_WIDTH-1:0]     b_edge_o,
   output logic                          start_operation_o,
   output logic                          busy_o,
   output logic                          result_valid_o,
   input  logic                          result_ack_i,
   output logic [31:0]                   stall_cnt_o
);

   localparam int KW  = $clog2(MAX_K + 1);
   localparam int DCW = $clog2(2 * DIM);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(drain_last(DIM));

   feed_state_t              state;
   logic [KW-1:0]            k_len;
   logic [KW-1:0]            beat_cnt;
   logic [DCW-1:0]           drain_cnt;
   logic                     accept;
   logic                     start_ok;
   logic [DIM*DATA_WIDTH-1:0] a_feed;
   logic [DIM*DATA_WIDTH-1:0] b_feed;

   assign accept   = in_valid_i && in_ready_o;
   assign start_ok = (state == ST_IDLE) && start_i && (k_len_i != '0);

   // A cycle without an accepted beat feeds a zero slice so lane alignment is kept.
   assign a_feed = accept ? a_vec_i : '0;
   assign b_feed = accept ? b_vec_i : '0;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state             <= ST_IDLE;
         k_len             <= '0;
         beat_cnt          <= '0;
         drain_cnt         <= '0;
         in_ready_o        <= 1'b0;
         start_operation_o <= 1'b0;
         busy_o            <= 1'b0;
         result_valid_o    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  state             <= ST_FEED;
                  k_len             <= KW'(clamp_k(int'(k_len_i), MAX_K));
                  beat_cnt          <= '0;
                  in_ready_o        <= 1'b1;
                  start_operation_o <= 1'b1;
                  busy_o            <= 1'b1;
               end
            end
            ST_FEED: begin
               if (accept) begin
                  if (beat_cnt == k_len - KW'(1)) begin
                     state      <= ST_DRAIN;
                     in_ready_o <= 1'b0;
                     drain_cnt  <= '0;
                  end else begin
                     beat_cnt <= beat_cnt + KW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state          <= ST_HOLD;
                  result_valid_o <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + DCW'(1);
               end
            end
            ST_HOLD: begin
               if (result_ack_i) begin
                  state             <= ST_IDLE;
                  result_valid_o    <= 1'b0;
                  start_operation_o <= 1'b0;
                  busy_o            <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Lane i is delayed i+1 edges so PE(i,j) sees A[i][k] and B[k][j] together.
   for (genvar i = 0; i < DIM; i++) begin : g_lane
      skew_line #(.DEPTH(i + 1), .WIDTH(DATA_WIDTH)) u_skew_a (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .d       (a_feed[i*DATA_WIDTH +: DATA_WIDTH]),
         .q       (a_edge_o[i*DATA_WIDTH +: DATA_WIDTH])
      );
      skew_line #(.DEPTH(i + 1), .WIDTH(DATA_WIDTH)) u_skew_b (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .d       (b_feed[i*DATA_WIDTH +: DATA_WIDTH]),
         .q       (b_edge_o[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

`ifdef FEEDER_STALL_CNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt <= '0;
      end else if (start_ok) begin
         stall_cnt <= '0;
      end else if ((state == ST_FEED) && !in_valid_i && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench: feeder driving a behavioural 4x4 MAC array; results scoreboarded against A*B.
module tb_systolic_feeder;

   localparam int DIM = 4;
   localparam int DW  = 8;

   logic              clk;
   logic              rst_n;
   logic              start_i;
   logic [7:0]        k_len_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [DIM*DW-1:0] a_vec_i;
   logic [DIM*DW-1:0] b_vec_i;
   logic [DIM*DW-1:0] a_edge;
   logic [DIM*DW-1:0] b_edge;
   logic              start_op;
   logic              busy_o;
   logic              result_valid_o;
   logic              result_ack_i;
   logic [31:0]       stall_cnt_o;

   systolic_feeder #(.DIM(DIM), .DATA_WIDTH(DW), .MAX_K(255)) dut (
      .clk_i             (clk),
      .rst_n_i           (rst_n),
      .start_i           (start_i),
      .k_len_i           (k_len_i),
      .in_valid_i        (in_valid_i),
      .in_ready_o        (in_ready_o),
      .a_vec_i           (a_vec_i),
      .b_vec_i           (b_vec_i),
      .a_edge_o          (a_edge),
      .b_edge_o          (b_edge),
      .start_operation_o (start_op),
      .busy_o            (busy_o),
      .result_valid_o    (result_valid_o),
      .result_ack_i      (result_ack_i),
      .stall_cnt_o       (stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural PE array: A flows right, B flows down, accumulate while start_operation is high.
   int a_w [DIM][DIM];
   int b_w [DIM][DIM];
   int pa  [DIM][DIM];
   int pb  [DIM][DIM];
   int acc [DIM][DIM];

   always_comb begin
      for (int i = 0; i < DIM; i++) begin
         a_w[i][0] = int'($signed(a_edge[i*DW +: DW]));
         b_w[0][i] = int'($signed(b_edge[i*DW +: DW]));
      end
      for (int i = 0; i < DIM; i++) begin
         for (int j = 1; j < DIM; j++) begin
            a_w[i][j] = pa[i][j-1];
            b_w[j][i] = pb[j-1][i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
               pa[i][j]  <= 0;
               pb[i][j]  <= 0;
               acc[i][j] <= 0;
            end
         end
      end else begin
         for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
               pa[i][j]  <= a_w[i][j];
               pb[i][j]  <= b_w[i][j];
               acc[i][j] <= start_op ? acc[i][j] + a_w[i][j] * b_w[i][j] : 0;
            end
         end
      end
   end

   typedef struct packed {
      logic [3:0][3:0][7:0] a;         // a[i][k]
      logic [3:0][3:0][7:0] b;         // b[k][j]
      logic [7:0]           k_len;
      logic [7:0]           bubbles;   // bit t set: in_valid low on FEED cycle t
      logic [7:0]           exp_stall;
      logic [7:0]           hold;      // cycles to keep ack low in HOLD
      logic                 poke;      // drive start_i and result_ack_i during FEED
   } vec_t;

   localparam int NVEC = 6;
   vec_t vecs [NVEC];
   int   exp_q [$];
   int   n_total;
   int   n_pass;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   c, e, feed_cyc, acc_n, t, cnt, nz, exp_st;
      logic bub;
      v = vecs[idx];
`ifdef FEEDER_STALL_CNT_EN
      exp_st = int'(v.exp_stall);
`else
      exp_st = 0;
`endif
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            c = 0;
            for (int k = 0; k < int'(v.k_len); k++) c += $signed(v.a[i][k]) * $signed(v.b[k][j]);
            exp_q.push_back(c);
         end
      end
      start_i = 1'b1;
      k_len_i = v.k_len;
      @(negedge clk);
      start_i = 1'b0;
      check($sformatf("v%0d busy", idx), busy_o, 1);
      check($sformatf("v%0d start_op", idx), start_op, 1);
      acc_n = 0; t = 0; feed_cyc = 0;
      while (acc_n < int'(v.k_len) && t < 64) begin
         bub = (t < 8) ? v.bubbles[t] : 1'b0;
         in_valid_i = !bub;
         for (int i = 0; i < DIM; i++) begin
            a_vec_i[i*DW +: DW] = v.a[i][acc_n];
            b_vec_i[i*DW +: DW] = v.b[acc_n][i];
         end
         if (v.poke) begin
            start_i      = 1'b1;
            k_len_i      = 8'd7;
            result_ack_i = 1'b1;
         end
         if (in_ready_o) feed_cyc++;
         if (in_valid_i && in_ready_o) acc_n++;
         t++;
         @(negedge clk);
      end
      in_valid_i = 1'b0; start_i = 1'b0; result_ack_i = 1'b0;
      a_vec_i = '0; b_vec_i = '0;
      check($sformatf("v%0d feed_cycles", idx), feed_cyc, int'(v.k_len) + int'(v.exp_stall));
      check($sformatf("v%0d ready_after_feed", idx), in_ready_o, 0);
      cnt = 0;
      while (!result_valid_o && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      check($sformatf("v%0d drain_cycles", idx), cnt, 2 * DIM - 1);
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            e = exp_q.pop_front();
            check($sformatf("v%0d acc(%0d,%0d)", idx, i, j), acc[i][j], e);
            if (v.hold != 0) begin
               exp_q.push_back(e);
            end
         end
      end
      check($sformatf("v%0d stall_cnt", idx), stall_cnt_o, exp_st);
      if (v.hold != 0) begin
         repeat (int'(v.hold)) @(negedge clk);
         check($sformatf("v%0d valid_held", idx), result_valid_o, 1);
         for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
               e = exp_q.pop_front();
               check($sformatf("v%0d held acc(%0d,%0d)", idx, i, j), acc[i][j], e);
            end
         end
      end
      result_ack_i = 1'b1;
      @(negedge clk);
      result_ack_i = 1'b0;
      check($sformatf("v%0d valid_after_ack", idx), result_valid_o, 0);
      check($sformatf("v%0d start_op_after_ack", idx), start_op, 0);
      check($sformatf("v%0d busy_after_ack", idx), busy_o, 0);
      @(negedge clk);
      nz = 0;
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++)
            if (acc[i][j] != 0) nz++;
      check($sformatf("v%0d acc_cleared", idx), nz, 0);
   endtask

   initial begin
      n_total = 0; n_pass = 0;
      rst_n = 1'b0; start_i = 1'b0; k_len_i = '0; in_valid_i = 1'b0;
      a_vec_i = '0; b_vec_i = '0; result_ack_i = 1'b0;

      for (int n = 0; n < NVEC; n++) vecs[n] = '0;
      for (int i = 0; i < DIM; i++) begin
         for (int k = 0; k < DIM; k++) begin
            vecs[0].a[i][k] = (i == k) ? 8'd1 : 8'd0;
            vecs[0].b[i][k] = (i == k) ? 8'd1 : 8'd0;
            vecs[1].a[i][k] = 8'(i + 1);
            vecs[1].b[i][k] = 8'(-(k + 1));
            vecs[3].a[i][k] = 8'($urandom);
            vecs[3].b[i][k] = 8'($urandom);
            vecs[4].a[i][k] = 8'h80;
            vecs[4].b[i][k] = 8'h80;
            vecs[5].a[i][k] = 8'($urandom);
            vecs[5].b[i][k] = 8'($urandom);
         end
      end
      vecs[2] = vecs[1];
      vecs[0].k_len = 8'd4;
      vecs[1].k_len = 8'd4; vecs[1].hold = 8'd20;
      vecs[2].k_len = 8'd4; vecs[2].bubbles = 8'b0000_0110; vecs[2].exp_stall = 8'd2;
      vecs[3].k_len = 8'd3; vecs[3].bubbles = 8'b0000_0001; vecs[3].exp_stall = 8'd1;
      vecs[3].poke  = 1'b1;
      vecs[4].k_len = 8'd4; vecs[4].bubbles = 8'b0000_1000; vecs[4].exp_stall = 8'd1;
      vecs[5].k_len = 8'd4;

      repeat (2) @(negedge clk);
      check("rst in_ready", in_ready_o, 0);
      check("rst start_op", start_op, 0);
      check("rst busy", busy_o, 0);
      check("rst result_valid", result_valid_o, 0);
      check("rst a_edge", a_edge, 0);
      check("rst b_edge", b_edge, 0);
      check("rst stall_cnt", stall_cnt_o, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // zero-length start is ignored
      start_i = 1'b1; k_len_i = 8'd0;
      @(negedge clk);
      start_i = 1'b0;
      check("klen0 busy", busy_o, 0);
      check("klen0 in_ready", in_ready_o, 0);
      check("klen0 start_op", start_op, 0);
      @(negedge clk);

      for (int n = 0; n < NVEC; n++) run_vec(n);

      // asynchronous reset in the middle of FEED
      start_i = 1'b1; k_len_i = 8'd4;
      @(negedge clk);
      start_i = 1'b0;
      for (int b = 0; b < 2; b++) begin
         in_valid_i = 1'b1;
         a_vec_i = {4{8'h11}}; b_vec_i = {4{8'h22}};
         @(negedge clk);
      end
      in_valid_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst busy", busy_o, 0);
      check("arst start_op", start_op, 0);
      check("arst in_ready", in_ready_o, 0);
      check("arst a_edge", a_edge, 0);
      check("arst b_edge", b_edge, 0);
      check("arst result_valid", result_valid_o, 0);
      check("arst stall_cnt", stall_cnt_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      a_vec_i = '0; b_vec_i = '0;
      @(negedge clk);
      run_vec(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
